// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver.
//   spi_state_e        : receiver FSM states (IDLE, SHIFT, HOLD)
//   FRAME_BITS_DEFAULT : default number of bits per SPI frame
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // cs high, waiting for a frame to start
    SHIFT = 2'd1,  // cs low, bits still being exchanged
    HOLD  = 2'd2   // frame complete, waiting for cs to return high
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with edge detection.
//   clk   : system clock
//   rst   : asynchronous active-high reset; all flops reset to RESET_VAL
//   din   : asynchronous input
//   level : synchronized level of din
//   rise  : one-clk pulse on a synchronized 0->1 transition
//   fall  : one-clk pulse on a synchronized 1->0 transition
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver/transmitter, CPHA=1 (mode 1 by default).
//   clk, rst   : system clock, asynchronous active-high reset
//   sck, cs    : SPI clock and active-low chip select (asynchronous)
//   mosi, miso : serial data in / out, MSB first
//   miso_oe    : miso drive enable, high while a frame is active
//   tx_data    : response word, captured when the frame starts
//   rx_data    : last complete received word
//   rx_valid   : one-clk pulse when rx_data updates
//   frame_err  : one-clk pulse when cs rises in the middle of a frame
//   busy       : inverted synchronized cs
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int SPI_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  // With CPHA=1 data is launched on the leading sck edge and captured on
  // the trailing one; CPOL decides which physical edge leads.
  localparam bit CPOL = (SPI_MODE >= 2);

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_s_q;
  logic launch, capture, last_bit;

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  // After reset the cs synchronizer starts at 1; if cs is really low, a
  // spurious falling edge appears once the pipeline flushes. Frames are
  // only accepted after cs has been genuinely observed high.
  logic [1:0]            settle_q, settle_d;
  logic                  armed_q, armed_d;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  assign launch  = CPOL ? sck_fall : sck_rise;
  assign capture = CPOL ? sck_rise : sck_fall;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    last_bit    = 1'b0;
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | (cs_s & (settle_q == 2'd3));

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d    = SHIFT;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          miso_oe_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (launch) begin
          miso_d     = tx_shift_q[FRAME_BITS-1];
          tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
        end
        if (capture) begin
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s_q};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            last_bit   = 1'b1;
            state_d    = HOLD;
            rx_data_d  = {rx_shift_q[FRAME_BITS-2:0], mosi_s_q};
            rx_valid_d = 1'b1;
          end
        end
        // A completing edge in the same cycle wins: the word is delivered
        // and the frame ends cleanly.
        if (cs_rise) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (!last_bit && (bit_cnt_q != '0 || capture)) begin
            frame_err_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (cs_rise) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      mosi_meta_q <= mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = ~cs_s;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a bit-banged mode-1 master at
// sck = clk/10, with expected received words queued on a scoreboard and
// popped whenever the DUT pulses rx_valid.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [15:0] tx_data = 16'h0000;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, busy;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          rx_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_rx #(.FRAME_BITS(16), .SPI_MODE(1)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every rx_valid cycle consumes one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check_val("rx_unexpected", {31'd0, rx_valid}, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("rx word 0x%04h (expected 0x%04h)", rx_data, e);
          check_val("rx_data", {16'd0, rx_data}, {16'd0, e});
        end
      end
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full sck period: drive mosi on the rising edge, sample miso on fall.
  task automatic sck_cycle(input logic b, output logic m);
    @(negedge clk);
    sck  = 1'b1;
    mosi = b;
    wait_clk(5);
    sck = 1'b0;
    m   = miso;
    wait_clk(4);
  endtask

  task automatic do_frame(input logic [15:0] word, input int nbits,
                          input logic [15:0] tx_exp, input int change_at,
                          input int gap);
    logic [15:0] got;
    logic        m;
    got = '0;
    cs  = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) tx_data = 16'hFFFF;
      sck_cycle((i < 16) ? word[15-i] : 1'b1, m);
      if (i < 16) got[15-i] = m;
      if (i == nbits / 2) begin
        check_val("miso_oe_mid", {31'd0, miso_oe}, 32'd1);
        check_val("busy_mid", {31'd0, busy}, 32'd1);
      end
    end
    wait_clk(3);
    cs = 1'b1;
    wait_clk(gap);
    if (nbits >= 16) check_val("miso_word", {16'd0, got}, {16'd0, tx_exp});
    if (gap >= 8) begin
      check_val("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
      check_val("miso_idle", {31'd0, miso}, 32'd0);
      check_val("busy_idle", {31'd0, busy}, 32'd0);
    end
    $display("frame mosi=0x%04h bits=%0d miso=0x%04h", word, nbits, got);
  endtask

  initial begin
    int          rx_base, err_base;
    logic        dummy;

    // Reset state
    wait_clk(3);
    check_val("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check_val("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_miso", {31'd0, miso}, 32'd0);
    check_val("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    rst = 1'b0;
    wait_clk(8);

    // Single frame
    tx_data = 16'h3C96;
    exp_q.push_back(16'hA840);
    do_frame(16'hA840, 16, 16'h3C96, -1, 10);
    check_val("single_rx_cnt", rx_cnt, 1);
    check_val("single_err_cnt", err_cnt, 0);

    // Back-to-back with 4 clk gap
    tx_data = 16'h0001;
    exp_q.push_back(16'hA840);
    do_frame(16'hA840, 16, 16'h0001, -1, 4);
    exp_q.push_back(16'hC080);
    do_frame(16'hC080, 16, 16'h0001, -1, 10);
    check_val("b2b_rx_cnt", rx_cnt, 3);
    check_val("b2b_err_cnt", err_cnt, 0);

    // tx_data changed mid-frame must not affect miso
    tx_data = 16'h5A3C;
    exp_q.push_back(16'h0F0F);
    do_frame(16'h0F0F, 16, 16'h5A3C, 8, 10);
    check_val("txchg_rx_cnt", rx_cnt, 4);

    // Aborted frame after 7 bits
    do_frame(16'hFFFF, 7, 16'h0000, -1, 10);
    check_val("abort_err_cnt", err_cnt, 1);
    check_val("abort_rx_cnt", rx_cnt, 4);
    check_val("abort_rx_keep", {16'd0, rx_data}, 32'h0F0F);

    // 17 sck cycles: 17th ignored
    tx_data = 16'h8001;
    exp_q.push_back(16'hBEEF);
    do_frame(16'hBEEF, 17, 16'h8001, -1, 10);
    check_val("extra_rx_cnt", rx_cnt, 5);
    check_val("extra_err_cnt", err_cnt, 1);
    check_val("extra_rx_data", {16'd0, rx_data}, 32'hBEEF);

    // Reset in the middle of a frame, cs kept low afterwards
    rx_base  = rx_cnt;
    err_base = err_cnt;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 9; i++) sck_cycle(i[0], dummy);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 16; i++) sck_cycle(1'b1, dummy);
    check_val("rstmid_miso_oe", {31'd0, miso_oe}, 32'd0);
    wait_clk(3);
    cs = 1'b1;
    wait_clk(10);
    check_val("rstmid_rx_cnt", rx_cnt, rx_base);
    check_val("rstmid_err_cnt", err_cnt, err_base);
    check_val("rstmid_rx_data", {16'd0, rx_data}, 32'd0);
    tx_data = 16'hA5A5;
    exp_q.push_back(16'h1234);
    do_frame(16'h1234, 16, 16'hA5A5, -1, 10);
    check_val("post_rst_rx_cnt", rx_cnt, rx_base + 1);
    check_val("post_rst_err_cnt", err_cnt, err_base);
    check_val("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
